// File: rtl/weight_ram_arbiter.sv
// Round-robin arbiter that shares one single-port weight RAM between three engines.
// Supports locked multi-beat ownership with a watchdog and fixed two-cycle read return.
module weight_ram_arbiter #(
  parameter int AWIDTH   = 4,
  parameter int DWIDTH   = 256,
  parameter int MAX_LOCK = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            req,
  input  logic [2:0]            lock,
  input  logic [2:0]            we,
  input  logic [3*AWIDTH-1:0]   addr,
  input  logic [3*DWIDTH-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DWIDTH-1:0]     rdata,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [DWIDTH-1:0]     mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  logic [AWIDTH-1:0] addr_a  [3];
  logic [DWIDTH-1:0] wdata_a [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      assign addr_a[gi]  = addr[gi*AWIDTH +: AWIDTH];
      assign wdata_a[gi] = wdata[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  // Read tag pipeline: stage 1 follows the transfer edge, stage 2 aligns with RAM output.
  logic              tag1_vld_q, tag1_vld_d;
  logic [1:0]        tag1_idx_q, tag1_idx_d;
  logic              tag2_vld_q, tag2_vld_d;
  logic [1:0]        tag2_idx_q, tag2_idx_d;

  logic              found;
  logic [1:0]        cand;
  logic              release_now;
  logic [CW-1:0]     cnt_inc;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_cnt_d  = lock_cnt_q;
    gnt_d       = gnt_q;
    rvalid_d    = 3'b000;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    tag1_vld_d  = 1'b0;
    tag1_idx_d  = tag1_idx_q;
    tag2_vld_d  = tag1_vld_q;
    tag2_idx_d  = tag1_idx_q;
    found       = 1'b0;
    cand        = 2'd0;
    release_now = 1'b0;
    cnt_inc     = lock_cnt_q + CW'(1);

    if (tag2_vld_q) begin
      rvalid_d = 3'b001 << tag2_idx_q;
      rdata_d  = mem_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < 3; k++) begin
          if (!found) begin
            cand = (int'(rr_ptr_q) + k >= 3) ? 2'(int'(rr_ptr_q) + k - 3)
                                             : 2'(int'(rr_ptr_q) + k);
            if (req[cand]) begin
              found      = 1'b1;
              owner_d    = cand;
              gnt_d      = 3'b001 << cand;
              lock_cnt_d = '0;
              state_d    = ST_OWNED;
            end
          end
        end
      end
      ST_OWNED: begin
        if (req[owner_q]) begin
          mem_addr_d  = addr_a[owner_q];
          mem_wdata_d = wdata_a[owner_q];
          mem_we_d    = we[owner_q];
          tag1_vld_d  = !we[owner_q];
          tag1_idx_d  = owner_q;
          lock_cnt_d  = cnt_inc;
          release_now = !lock[owner_q] || (cnt_inc == CW'(MAX_LOCK));
        end else begin
          release_now = 1'b1;
        end
        if (release_now) begin
          gnt_d    = 3'b000;
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      lock_cnt_q  <= '0;
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tag1_vld_q  <= 1'b0;
      tag1_idx_q  <= 2'd0;
      tag2_vld_q  <= 1'b0;
      tag2_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_idx_q  <= tag1_idx_d;
      tag2_vld_q  <= tag2_vld_d;
      tag2_idx_q  <= tag2_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// Bench for weight_ram_arbiter: directed scenarios then random traffic, all outputs
// compared every cycle against a transaction-level model of the arbiter and RAM.
module tb_weight_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 256;
  localparam int ML = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [2:0]     req, lock, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]     gnt, rvalid;
  logic [DW-1:0]  rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]  mem_addr;
  logic           mem_we;

  weight_ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(ML)) dut (
    .CLK(CLK), .RST(RST), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Physical RAM: registered read, write on mem_we.
  logic [DW-1:0] ram [16];
  always_ff @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [DW-1:0] mdl_mem [16];
  int            m_owner, m_rr, m_cnt, cyc;
  logic          pv [4];
  int            pwho [4];
  logic [DW-1:0] pdata [4];
  logic [2:0]    e_gnt, e_rvalid;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;
  logic          e_we;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic model_edge();
    int i, s;
    logic [AW-1:0] a;
    logic rel;
    cyc++;
    if (RST) begin
      m_owner = -1; m_rr = 0; m_cnt = 0;
      for (int k = 0; k < 4; k++) pv[k] = 1'b0;
      e_gnt = 0; e_rvalid = 0; e_rdata = '0; e_addr = '0; e_wdata = '0; e_we = 0;
      return;
    end
    e_we = 1'b0;
    e_rvalid = 3'b000;
    s = cyc % 4;
    if (pv[s]) begin
      e_rvalid = 3'(1 << pwho[s]);
      e_rdata  = pdata[s];
      pv[s]    = 1'b0;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < 3; k++) begin
        i = (m_rr + k) % 3;
        if (m_owner < 0 && req[i]) begin
          m_owner = i; m_cnt = 0; e_gnt = 3'(1 << i);
        end
      end
    end else begin
      i = m_owner;
      rel = 1'b1;
      if (req[i]) begin
        a = addr[i*AW +: AW];
        e_addr  = a;
        e_wdata = wdata[i*DW +: DW];
        e_we    = we[i];
        if (we[i]) mdl_mem[a] = wdata[i*DW +: DW];
        else begin
          pv[(cyc + 2) % 4]    = 1'b1;
          pwho[(cyc + 2) % 4]  = i;
          pdata[(cyc + 2) % 4] = mdl_mem[a];
        end
        m_cnt++;
        rel = !lock[i] || (m_cnt == ML);
      end
      if (rel) begin
        m_owner = -1; m_rr = (i + 1) % 3; e_gnt = 3'b000;
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w);
    RST = r; req = rq; lock = lk; we = w;
    @(posedge CLK);
    model_edge();
    #1;
    check("gnt", DW'(gnt), DW'(e_gnt));
    check("rvalid", DW'(rvalid), DW'(e_rvalid));
    check("rdata", rdata, e_rdata);
    check("mem_addr", DW'(mem_addr), DW'(e_addr));
    check("mem_we", DW'(mem_we), DW'(e_we));
    check("mem_wdata", mem_wdata, e_wdata);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] a5;
    logic          r;
    for (int k = 0; k < 16; k++) begin
      w = rnd_word();
      ram[k] = w;
      mdl_mem[k] = w;
    end
    m_owner = -1; m_rr = 0; m_cnt = 0; cyc = 0;
    for (int k = 0; k < 4; k++) pv[k] = 1'b0;
    RST = 1'b1; req = 0; lock = 0; we = 0; addr = '0; wdata = '0;
    for (int k = 0; k < 3; k++) set_port(k, AW'(k + 3), rnd_word());

    // Reset, then a single read of addr 3 by requester 1
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    set_port(1, 4'd3, rnd_word());
    step(0, 3'b010, 0, 0);
    step(0, 3'b010, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // All three requesting, unlocked and held
    for (int k = 0; k < 12; k++) step(0, 3'b111, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);

    // Locked read-modify-write of addr 1 by requester 2
    for (int k = 0; k < DW / 8; k++) a5[k*8 +: 8] = 8'hA5;
    set_port(2, 4'd1, rnd_word());
    step(0, 3'b100, 3'b100, 0);
    step(0, 3'b100, 3'b100, 0);
    set_port(2, 4'd1, a5);
    step(0, 3'b100, 3'b000, 3'b100);
    step(0, 0, 0, 0);
    step(0, 3'b100, 0, 0);
    step(0, 3'b100, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // Lock watchdog: requester 0 holds lock while requester 1 waits
    set_port(0, 4'd5, rnd_word());
    for (int k = 0; k < 13; k++) step(0, 3'b011, 3'b001, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // Reset in the middle of a locked read burst
    for (int k = 0; k < 3; k++) step(0, 3'b001, 3'b001, 0);
    step(1, 3'b001, 3'b001, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);

    // Grant abandoned by requester 0, then simultaneous request resolved by rr_ptr
    step(0, 3'b001, 0, 3'b001);
    step(0, 0, 0, 3'b001);
    step(0, 0, 0, 0);
    step(0, 3'b111, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);

    // Random traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 3; k++) set_port(k, AW'($urandom_range(0, 15)), rnd_word());
      r = ($urandom_range(0, 63) == 0);
      step(r, 3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/weight_ram_arbiter.md
# weight_ram_arbiter

Round-robin arbiter sharing the single-port 256-bit weight RAM between three requesters: host weight loader (0), forward-pass sequencer (1) and weight-update sequencer (2). It sits between those engines and the RAM instance. It registers all RAM-side signals and returns read data with a fixed latency. It supports locked multi-beat ownership so a requester can complete a read-modify-write of a weight row, bounded by a lock watchdog.

## Interface
- AWIDTH, 4, RAM address width
- DWIDTH, 256, RAM word width
- MAX_LOCK, 8, maximum transfers per locked grant before forced release (≥1)
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req  in  3  per-requester access request
- lock  in  3  per-requester hold-grant request, meaningful only while req is high
- we  in  3  per-requester write enable (1 = write, 0 = read)
- addr  in  3*AWIDTH  per-requester address; requester i at [i*AWIDTH +: AWIDTH]
- wdata  in  3*DWIDTH  per-requester write data; requester i at [i*DWIDTH +: DWIDTH]
- gnt  out  3  registered one-hot grant
- rvalid  out  3  registered one-hot read-data-valid
- rdata  out  DWIDTH  registered read data, shared by all requesters
- mem_addr  out  AWIDTH  RAM address
- mem_wdata  out  DWIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DWIDTH  RAM read data; valid one cycle after mem_addr is presented

## Operation
- Internal state: IDLE (gnt = 0) or OWNED (exactly one gnt bit high). Also rr_ptr (0..2) and lock_cnt (0..MAX_LOCK).
- IDLE, some req high at edge: winner = first i with req[i] high, searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Set gnt[winner], lock_cnt <= 0, go to OWNED.
- IDLE, no req: remain IDLE.
- Transfer: any edge with gnt[i] and req[i] high.
  - On that edge: mem_addr <= addr_i, mem_wdata <= wdata_i, mem_we <= we[i], lock_cnt <= lock_cnt+1.
  - mem_we is 0 after any edge with no transfer, so a write is a one-cycle mem_we pulse per transfer.
- OWNED by i, evaluated at every edge:
  - req[i] low: release with no transfer.
  - req[i] high, lock[i] low: transfer, then release.
  - req[i] high, lock[i] high, lock_cnt+1 < MAX_LOCK: transfer and keep the grant.
  - req[i] high, lock[i] high, lock_cnt+1 = MAX_LOCK: transfer, then forced release.
- Release: gnt <= 0, rr_ptr <= (i+1) mod 3, go to IDLE. One idle arbitration cycle always separates two owners.
- Read return: a read transfer on edge E sets a 2-stage tag pipeline.
  - On edge E+2: rdata <= mem_rdata, rvalid[i] <= 1 for exactly one cycle.
  - Otherwise rvalid = 0; rdata holds its last value.
  - Writes produce no rvalid.
- Ordering: transfers reach the RAM in edge order, so a write followed by a read of the same address returns the new data.
- Inputs addr, wdata and we are sampled only at transfer edges. Requesters must hold req until they see gnt.

## Timing
- Reset values: gnt = 0, rvalid = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0, rr_ptr = 0, lock_cnt = 0.
- Reset overrides everything. A reset asserted mid-burst or with reads in flight drops the grant and kills the tag pipeline: no rvalid after reset for pre-reset reads.
- Request to grant: req high before edge N in IDLE → gnt high after edge N.
- Grant to first transfer: edge N+1.
- Transfer to mem_addr: mem_addr valid after the transfer edge.
- Read latency: rvalid/rdata 2 cycles after the transfer edge.
- Locked burst: one transfer per cycle. A read on every cycle gives back-to-back rvalid pulses.
- Unlocked single access occupies 2 edges: grant, then transfer/release. Next owner gnt follows one edge later.
- Simultaneous requests in IDLE resolve by rr_ptr only; there is no fixed priority.
- A requester that drops req while granted receives no transfer. The grant is released on that edge.

## Test plan
- Reset, then single read: req[1]=1, we=0, addr=3. Required: gnt=3'b010 after edge 1, mem_addr=3 after edge 2, rvalid=3'b010 with rdata=RAM[3] after edge 4, then gnt=0.
- All three req high from reset, unlocked, held. Required: grant order 0,1,2,0 with one idle cycle between owners; each owner gets exactly one transfer.
- Locked read-modify-write by requester 2: read addr 1, then write 0xA5.. to addr 1, lock dropped on the write. Required: two consecutive transfers, single mem_we pulse, a subsequent read of addr 1 returns 0xA5...
- Lock watchdog: MAX_LOCK=8, requester 0 holds req and lock while requester 1 requests. Required: exactly 8 transfers, forced release, then gnt=3'b010.
- Reset mid-burst: RST after 2 locked reads with reads in flight. Required: all outputs at reset values next cycle; no rvalid for the in-flight reads.
- Grant abandoned: req[0] dropped the cycle after gnt[0] rises. Required: no mem_we, no rvalid, gnt=0, rr_ptr=1.
